// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with an input FIFO. Bytes are accepted over a valid/ready
// handshake, queued, and serialized as start + 8 data bits (LSB first) + stop
// on o_txd. When another byte is queued at the end of a stop bit, the next
// start bit follows immediately, so consecutive frames have no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : an even-parity bit is inserted between the data bits and the
//               stop bit (11-bit frame).
//   undefined : plain 8N1 (10-bit frame).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   i_data        byte to transmit
//   i_valid       i_data valid; accepted when i_valid && o_ready
//   o_ready       FIFO not full
//   o_txd         registered serial output, idles high
//   o_busy        high whenever the transmitter is not idle
//   o_fifo_count  bytes queued, not counting the byte being shifted out
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_txd,
  output logic             o_busy,
  output logic [FIFO_AW:0] o_fifo_count
);

  localparam int               DATA_W   = 8;
  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  // Even parity over the data byte: the parity bit makes the total count of
  // ones (data + parity) even, i.e. it is the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // FIFO storage and control
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count_q;
  logic               push;
  logic               pop;
  logic               fifo_nonempty;
  logic [DATA_W-1:0]  head;

  // Transmitter state
  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               bit_done;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  assign o_ready       = (count_q != FULL_CNT);
  assign push          = i_valid && o_ready;
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem[rd_ptr];
  assign bit_done      = (cnt_q == BIT_LAST);

  assign o_txd         = txd_q;
  assign o_busy        = busy_q;
  assign o_fifo_count  = count_q;

  // ---------------------------------------------------------------------------
  // FIFO: storage is data-only; pointers and count are control.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: next-state, next-output and pop request.
  // o_txd/o_busy are computed here one cycle ahead and registered with the
  // state, so the line level always changes on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(head);
`endif
          state_d = S_START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            // The next bit on the line is what lands in bit 0 after the shift.
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next frame when a byte is waiting; a byte
          // pushed on this same edge is not yet counted and goes via IDLE.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(head);
`endif
            state_d = S_START;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers: reset forces an idle line and abandons any frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers: only meaningful after a pop loads them, so no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo. Accepted bytes are queued as expected
// results; a serial decoder on o_txd rebuilds each frame and compares it with
// the head of the queue. A short bit period keeps the run small; all timing
// expectations are written in terms of CPB and FRAME.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB = 16;
  localparam int AW  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    i_data = 8'h00;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          o_txd;
  logic          o_busy;
  logic [AW:0]   o_fifo_count;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_txd       (o_txd),
    .o_busy      (o_busy),
    .o_fifo_count(o_fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];
  logic       mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Serial decoder, sampling mid-bit on the falling edge.
  logic       m_active = 1'b0;
  int         m_cnt = 0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_exp = 8'h00;
  logic       m_par = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (o_txd == 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
        starts_q.push_back(cyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt % CPB == CPB / 2) begin
        m_k = m_cnt / CPB;
        if (m_k == 0) begin
          check("start_bit", o_txd, 0);
        end else if (m_k <= 8) begin
          m_byte[m_k-1] = o_txd;
        end else if (m_k < NBITS - 1) begin
          m_par = o_txd;
        end else begin
          check("stop_bit", o_txd, 1);
          check("frame_expected", exp_q.size(), 1 + ((exp_q.size() > 1) ? exp_q.size() - 1 : 0));
          if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            check("byte", m_byte, m_exp);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", m_par, ^m_exp);
`endif
          end
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit acc);
    i_data  = d;
    i_valid = 1'b1;
    if (acc) exp_q.push_back(d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, (n < budget), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int to_err;
    int n;
    int bad;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_txd", o_txd, 1);
    check("rst_busy", o_busy, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_ready", o_ready, 1);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (5) tick();

    // Single byte: latency, bit timing (via decoder), busy duration
    starts_q.delete();
    push(8'h95, 1'b1);
    check("t1_cnt_after_push", o_fifo_count, 1);
    check("t1_txd_pre", o_txd, 1);
    tick();
    check("t1_txd_start", o_txd, 0);
    check("t1_busy_start", o_busy, 1);
    check("t1_cnt_popped", o_fifo_count, 0);
    repeat (FRAME - 1) tick();
    check("t1_busy_hold", o_busy, 1);
    tick();
    check("t1_busy_drop", o_busy, 0);
    check("t1_txd_idle", o_txd, 1);
    check("t1_decoded", exp_q.size(), 0);
    repeat (4) tick();

    // Back-to-back frames with no gap
    starts_q.delete();
    push(8'hAA, 1'b1);
    push(8'hFF, 1'b1);
    drain("t2_drain", 4 * FRAME);
    check("t2_frames", starts_q.size(), 2);
    check("t2_gap", (starts_q.size() >= 2) ? starts_q[1] - starts_q[0] : -1, FRAME);
    repeat (4) tick();

    // FIFO full and drop
    push(8'h55, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    check("t3_count_full", o_fifo_count, 16);
    check("t3_ready_low", o_ready, 0);
    push(8'hEE, 1'b0);
    check("t3_count_after_drop", o_fifo_count, 16);
    drain("t3_drain", 20 * FRAME);
    check("t3_count_empty", o_fifo_count, 0);
    repeat (4) tick();

    // Pointer wrap: 40 bytes gated by o_ready
    to_err = 0;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (!o_ready && n < 2 * FRAME) begin
        tick();
        n++;
      end
      if (n >= 2 * FRAME) to_err++;
      push(8'(i), 1'b1);
    end
    check("t4_ready_wait", to_err, 0);
    drain("t4_drain", 20 * FRAME);
    check("t4_count_zero", o_fifo_count, 0);
    check("t4_busy_zero", o_busy, 0);
    repeat (4) tick();

    // Reset in the middle of data bit 3 with bytes queued
    push(8'h95, 1'b1);
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    repeat (4 * CPB + CPB / 2 - 2) tick();
    check("t5_mid_busy", o_busy, 1);
    check("t5_mid_count", o_fifo_count, 3);
    check("t5_bit3", o_txd, 0);
    mon_en = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    tick();
    check("t5_rst_txd", o_txd, 1);
    check("t5_rst_count", o_fifo_count, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_ready", o_ready, 1);
    reset  = 1'b1;
    mon_en = 1'b1;
    bad = 0;
    repeat (3 * FRAME) begin
      tick();
      if (o_txd == 1'b0 || o_busy) bad++;
    end
    check("t5_no_restart", bad, 0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x95 has even weight (bit 0), 0x07 odd weight (bit 1)
    starts_q.delete();
    push(8'h95, 1'b1);
    push(8'h07, 1'b1);
    drain("t6_drain", 4 * FRAME);
    check("t6_frames", starts_q.size(), 2);
    check("t6_gap", (starts_q.size() >= 2) ? starts_q[1] - starts_q[0] : -1, 11 * CPB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
